// File: rtl/frame_cap_pkg.sv
// Shared types and defaults for the sync frame capture slice.
package frame_cap_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CAPTURE = 2'd1,
    PARITY  = 2'd2
  } state_t;

  localparam int unsigned DEF_PAYLOAD_W = 8;
  localparam int unsigned DEF_CNT_W     = 8;

  function automatic int unsigned bit_cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sync_frame_capture_if.sv
// Valid/ready output bus of the frame capture stage.
interface sync_frame_capture_if #(
  parameter int unsigned PAYLOAD_W = frame_cap_pkg::DEF_PAYLOAD_W
);
  logic [PAYLOAD_W-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 par_err;

  modport master (output data_out, output data_valid, output par_err, input data_ready);
  modport slave  (input data_out, input data_valid, input par_err, output data_ready);
endinterface

// File: rtl/frame_sipo.sv
// Serial-in parallel-out shift register, MSB = first bit shifted in.
module frame_sipo #(
  parameter int unsigned PAYLOAD_W = frame_cap_pkg::DEF_PAYLOAD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 din,
  output logic [PAYLOAD_W-1:0] q,
  output logic [PAYLOAD_W-1:0] q_nxt
);

  // Truncating cast drops the oldest bit and stays valid for PAYLOAD_W=1.
  assign q_nxt = PAYLOAD_W'({q, din});

  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (en)    q <= q_nxt;
  end

endmodule

// File: rtl/sync_frame_capture.sv
// Captures PAYLOAD_W serial bits after each sync match into a valid/ready register.
// Optional trailing even-parity bit when FRAME_PARITY_CHECK_EN is defined.
module sync_frame_capture
  import frame_cap_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 det,
  sync_frame_capture_if.master fif,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int unsigned BCW = bit_cnt_w(PAYLOAD_W);

  state_t                 state, state_nxt;
  logic [BCW-1:0]         bit_cnt;
  logic                   last_bit;
  logic                   sr_clr, sr_en;
  logic [PAYLOAD_W-1:0]   sr_q, sr_nxt;
  logic                   frame_done;
  logic [PAYLOAD_W-1:0]   word;
  logic                   load;
`ifdef FRAME_PARITY_CHECK_EN
  logic                   perr;
`endif

  frame_sipo #(.PAYLOAD_W(PAYLOAD_W)) u_sipo (
    .clk   (clk),
    .rst   (rst),
    .clr   (sr_clr),
    .en    (sr_en),
    .din   (din),
    .q     (sr_q),
    .q_nxt (sr_nxt)
  );

  assign last_bit = (bit_cnt == BCW'(PAYLOAD_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sr_clr     = 1'b0;
    sr_en      = 1'b0;
    frame_done = 1'b0;
    word       = sr_nxt;
`ifdef FRAME_PARITY_CHECK_EN
    perr       = 1'b0;
`endif
    case (state)
      HUNT: begin
        sr_clr = 1'b1;
        if (det) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        sr_en = 1'b1;
        if (last_bit) begin
`ifdef FRAME_PARITY_CHECK_EN
          state_nxt = PARITY;
`else
          state_nxt  = HUNT;
          frame_done = 1'b1;
`endif
        end
      end
`ifdef FRAME_PARITY_CHECK_EN
      PARITY: begin
        state_nxt  = HUNT;
        frame_done = 1'b1;
        word       = sr_q;
        perr       = ^{sr_q, din};
      end
`endif
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state != CAPTURE) bit_cnt <= '0;
    else                         bit_cnt <= bit_cnt + 1'b1;
  end

  // A completing frame may overwrite a word that is being accepted this cycle.
  assign load = frame_done && (!fif.data_valid || fif.data_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      fif.data_out   <= '0;
      fif.data_valid <= 1'b0;
    end else if (load) begin
      fif.data_out   <= word;
      fif.data_valid <= 1'b1;
    end else if (fif.data_valid && fif.data_ready) begin
      fif.data_valid <= 1'b0;
    end
  end

`ifdef FRAME_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)       fif.par_err <= 1'b0;
    else if (load) fif.par_err <= perr;
  end
`else
  assign fif.par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)                                         drop_cnt <= '0;
    else if (frame_done && !load && drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
  end

endmodule

// File: tb/tb_sync_frame_capture.sv
// Self-checking bench for sync_frame_capture with a bit-queue reference model.
module tb_sync_frame_capture;
  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 2;
`ifdef FRAME_PARITY_CHECK_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int unsigned FRAME_BITS = W + PBITS;
  localparam int unsigned DROP_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, din, det;
  logic [CNT_W-1:0] drop_cnt;

  sync_frame_capture_if #(.PAYLOAD_W(W)) fif ();

  sync_frame_capture #(.PAYLOAD_W(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .det      (det),
    .fif      (fif),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_cap;
  bit          m_bits[$];
  bit          m_valid;
  int unsigned m_data;
  bit          m_perr;
  int unsigned m_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit d, input bit dt, input bit r, input bit rs);
    bit done;
    int unsigned wv;
    bit px;
    done = 0; wv = 0; px = 0;
    if (rs) begin
      m_cap = 0; m_bits.delete(); m_valid = 0; m_data = 0; m_perr = 0; m_drop = 0;
      return;
    end
    if (!m_cap) begin
      if (dt) begin m_cap = 1; m_bits.delete(); end
    end else begin
      m_bits.push_back(d);
      if (m_bits.size() == FRAME_BITS) begin
        done  = 1;
        m_cap = 0;
        for (int i = 0; i < W; i++) wv = wv * 2 + m_bits[i];
        foreach (m_bits[i]) px ^= m_bits[i];
      end
    end
    if (done) begin
      if (!m_valid || r) begin
        m_valid = 1; m_data = wv; m_perr = (PBITS != 0) ? px : 1'b0;
      end else if (m_drop < DROP_MAX) begin
        m_drop++;
      end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input bit d, input bit dt, input bit r, input bit rs);
    din = d; det = dt; fif.data_ready = r; rst = rs;
    @(posedge clk);
    model_edge(d, dt, r, rs);
    #1;
    chk("data_valid", {31'b0, fif.data_valid}, {31'b0, m_valid});
    chk("data_out",   32'(fif.data_out), m_data);
    chk("par_err",    {31'b0, fif.par_err}, {31'b0, m_perr});
    chk("drop_cnt",   32'(drop_cnt), m_drop);
  endtask

  // det cycle, then payload MSB-first, then optional parity bit; ready only on the last cycle
  task automatic send_frame(input logic [W-1:0] w, input bit pbit, input bit last_rdy,
                            input logic [W-1:0] detmask);
    step(0, 1, 0, 0);
    for (int k = 0; k < W; k++) begin
      bit lr;
      lr = (k == W - 1 && PBITS == 0) ? last_rdy : 1'b0;
      step(w[W-1-k], detmask[k], lr, 0);
    end
    if (PBITS != 0) step(pbit, 0, last_rdy, 0);
  endtask

  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_valid", {31'b0, fif.data_valid}, 32'd0);
    chk("rst_data",  32'(fif.data_out), 32'd0);
    chk("rst_drop",  32'(drop_cnt), 32'd0);
    step(0, 0, 0, 0);

    // basic frame and accept
    send_frame(8'hA5, 0, 0, '0);
    chk("basic_data",  32'(fif.data_out), 32'hA5);
    chk("basic_valid", {31'b0, fif.data_valid}, 32'd1);
    step(0, 0, 1, 0);
    chk("basic_clear", {31'b0, fif.data_valid}, 32'd0);

    // backpressure drop
    send_frame(8'h3C, 0, 0, '0);
    send_frame(8'hC3, 0, 0, '0);
    chk("bp_data", 32'(fif.data_out), 32'h3C);
    chk("bp_drop", 32'(drop_cnt), 32'd1);
    step(0, 0, 1, 0);
    chk("bp_clear", {31'b0, fif.data_valid}, 32'd0);

    // same-cycle accept and load
    step(0, 0, 0, 1);
    send_frame(8'h11, 0, 0, '0);
    send_frame(8'h22, 0, 1, '0);
    chk("swap_data",  32'(fif.data_out), 32'h22);
    chk("swap_valid", {31'b0, fif.data_valid}, 32'd1);
    chk("swap_drop",  32'(drop_cnt), 32'd0);
    step(0, 0, 1, 0);

    // det inside payload is ignored
    send_frame(8'h99, 0, 0, 8'b0010_0100);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("detcap_data", 32'(fif.data_out), 32'h99);
    chk("detcap_drop", 32'(drop_cnt), 32'd0);
    step(0, 0, 1, 0);

    // reset mid-capture with a frame pending
    send_frame(8'h77, 0, 0, '0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("midrst_valid", {31'b0, fif.data_valid}, 32'd0);
    chk("midrst_data",  32'(fif.data_out), 32'd0);
    send_frame(8'h5A, 0, 0, '0);
    chk("midrst_new", 32'(fif.data_out), 32'h5A);

    // drop counter saturation
    step(0, 0, 0, 1);
    for (int f = 0; f < 5; f++) send_frame(8'(f * 37 + 1), 0, 0, '0);
    chk("sat_drop", 32'(drop_cnt), 32'd3);

`ifdef FRAME_PARITY_CHECK_EN
    step(0, 0, 0, 1);
    send_frame(8'hA5, 1, 0, '0);
    chk("par_err1", {31'b0, fif.par_err}, 32'd1);
    step(0, 0, 1, 0);
    send_frame(8'hA5, 0, 0, '0);
    chk("par_err0", {31'b0, fif.par_err}, 32'd0);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit rd;
      rd = (n % 600 < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(1'($urandom), $urandom_range(0, 5) == 0, rd, $urandom_range(0, 399) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
